// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state type and opcode legality check for alu_dispatch
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_INC   = 4'b0001;
    localparam logic [3:0] OP_NEG   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_PASSA = 4'b0100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_INC) || (op == OP_NEG) ||
               (op == OP_SUB) || (op == OP_PASSA);
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// rtl/alu_op_fifo.sv - request FIFO of {op, a, b, tag} entries with registered head fields
module alu_op_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [3:0]               push_op,
    input  logic [DATA_W-1:0]        push_a,
    input  logic [DATA_W-1:0]        push_b,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [3:0]               head_op,
    output logic [DATA_W-1:0]        head_a,
    output logic [DATA_W-1:0]        head_b,
    output logic [TAG_W-1:0]         head_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [3:0]        op_mem  [DEPTH];
    logic [DATA_W-1:0] a_mem   [DEPTH];
    logic [DATA_W-1:0] b_mem   [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is never reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            op_mem[wr_ptr]  <= push_op;
            a_mem[wr_ptr]   <= push_a;
            b_mem[wr_ptr]   <= push_b;
            tag_mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_op  = op_mem[rd_ptr];
    assign head_a   = a_mem[rd_ptr];
    assign head_b   = b_mem[rd_ptr];
    assign head_tag = tag_mem[rd_ptr];

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - buffers ALU requests, issues them from registers and holds each result for the consumer
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic [3:0]               alu_op,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic                     alu_n,
    input  logic                     alu_z,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic                     res_n,
    output logic                     res_z,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_illegal,
    output logic [$clog2(DEPTH):0]   count
);
    state_t            state;
    state_t            next_state;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              head_legal;
    logic [3:0]        head_op;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [TAG_W-1:0]  head_tag;

    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign head_legal = is_legal_op(head_op);

    alu_op_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_op  (in_op),
        .push_a   (in_a),
        .push_b   (in_b),
        .push_tag (in_tag),
        .pop      (pop),
        .head_op  (head_op),
        .head_a   (head_a),
        .head_b   (head_b),
        .head_tag (head_tag),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Leaving RESULT also considers a push landing on the same edge, so no idle bubble.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty) next_state = DRIVE;
            DRIVE:   next_state = RESULT;
            RESULT:  if (res_ready) next_state = (!empty || push) ? DRIVE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        res_valid = 1'b0;
        alu_op    = OP_PASSA;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            DRIVE: begin
                pop = 1'b1;
                if (head_legal) begin
                    alu_op = head_op;
                    alu_a  = head_a;
                    alu_b  = head_b;
                end
            end
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data    <= '0;
            res_n       <= 1'b0;
            res_z       <= 1'b0;
            res_tag     <= '0;
            res_illegal <= 1'b0;
        end else if (state == DRIVE) begin
            res_data    <= head_legal ? alu_out : '0;
            res_n       <= head_legal && alu_n;
            res_z       <= head_legal && alu_z;
            res_tag     <= head_tag;
            res_illegal <= !head_legal;
        end
    end

endmodule
